rst_sequencer: RTL and testbench
================================

Name: rst_sequencer

Overview:
Reset sequencer between the clock/reset generator and the SoC reset domains. Takes the synchronized system reset, a clock-stable indication and a software reset request. Releases NUM_STAGES reset outputs in a fixed order with programmable spacing. Re-enters reset on lock loss, software request or (optionally) watchdog timeout, and records the cause.

Parameters:
NUM_STAGES, 3, number of sequenced reset outputs (>=1); bit 0 released first
HOLD_CYCLES, 32, minimum clk cycles all stages stay asserted after any reset cause (>=1)
STAGE_DELAY, 16, clk cycles between successive stage releases (>=1)
WDT_CYCLES, 1048576, watchdog timeout in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
locked  input  1  clock source stable; synchronous to clk
sw_rst_req  input  1  single-cycle software reset request
wdt_kick  input  1  watchdog restart pulse (ignored without the optional feature)
stage_rst_n  output  NUM_STAGES  per-domain active-low resets
all_released  output  1  high when every stage is released
rst_cause  output  2  last reset cause: 00 ext/power-on, 01 lock loss, 10 software, 11 watchdog

Behaviour:
- Reset (rst_n=0, asynchronous): state=HOLD, counters=0, stage index=0, stage_rst_n all 0, all_released=0, rst_cause=00.
- Edge numbering: edge 1 is the first rising clk edge after rst_n deasserts.
- FSM states are HOLD, RELEASE and RUN.
- HOLD:
  - stage_rst_n all 0.
  - The hold counter increments on each edge with locked=1 and clears to 0 on any edge with locked=0.
  - On the edge where the count reaches HOLD_CYCLES, go to RELEASE with the delay counter=0 and stage index=0.
- RELEASE:
  - The delay counter increments every edge.
  - On the edge where it reaches STAGE_DELAY, set stage_rst_n[index] to 1, increment index and clear the counter.
  - Stage k is released on edge HOLD_CYCLES+(k+1)*STAGE_DELAY, measured from the start of locked-high counting.
  - Released bits stay 1 while in RELEASE/RUN.
  - On the edge releasing the last stage, also set all_released=1 and go to RUN.
- RUN: all outputs held.
- Abort causes, in priority order:
  - locked=0: cause 01.
  - watchdog timeout: cause 11.
  - sw_rst_req=1: cause 10.
- Abort handling in RELEASE or RUN: on the same edge, stage_rst_n goes to all 0, all_released goes to 0, rst_cause is updated and state goes to HOLD with the hold counter cleared.
- Abort handling in HOLD: locked=0 clears the counter without changing the cause. sw_rst_req clears the counter and sets cause 10 only if locked=1.
- rst_cause is sticky until the next cause. It is readable while the stages are released.
- Counter width: $clog2(max(HOLD_CYCLES,STAGE_DELAY)+1). No wrap is possible, because the counter clears at its terminal count.
- NUM_STAGES=1: the single release goes directly to RUN.
- rst_n asserted mid-sequence: immediate asynchronous return to reset values.

Optional Feature:
Macro RST_SEQ_WDT_EN.
- When defined:
  - A $clog2(WDT_CYCLES+1)-bit watchdog counter runs only in RUN.
  - It clears on entry to RUN and on any edge with wdt_kick=1.
  - On the edge it reaches WDT_CYCLES, the sequencer aborts with cause 11.
- When undefined: no watchdog logic, wdt_kick is ignored and cause 11 is never produced.

Test Plan:
- Power-up with defaults: rst_n low 5 cycles then high, locked=1 steady -> stage_rst_n=000 until edge 48; 001 at edge 48, 011 at 64, 111 at 80; all_released=1 at edge 80; rst_cause=00.
- locked=0 on edges 20-29, 1 from edge 30 -> HOLD completes at edge 61; stages released at 77, 93, 109; rst_cause stays 00.
- In RUN, sw_rst_req pulse sampled at edge E -> stage_rst_n=000 and all_released=0 after edge E; rst_cause=10; stages released at E+48, E+64, E+80.
- In RUN, locked=0 and sw_rst_req=1 on the same edge -> rst_cause=01. Hold counting restarts only once locked=1.
- rst_n driven low between clock edges after stage 0 is released (edge 55) -> stage_rst_n=000, all_released=0, rst_cause=00 immediately, before the next edge.
- RST_SEQ_WDT_EN defined with WDT_CYCLES=100:
  - No kicks after entering RUN at edge 80 -> abort at edge 180 with rst_cause=11.
  - wdt_kick every 50 cycles -> stays in RUN indefinitely.

Source files
------------

// File: rtl/rst_sequencer_if.sv
// Reset-sequencer handshake bundle: clock/lock status and reset requests in,
// per-domain resets and cause reporting out.
// slave  : the sequencer itself.
// master : the surrounding clock/reset infrastructure and reset consumers.
interface rst_sequencer_if #(
   parameter int NUM_STAGES = 3
);
   logic                  locked;
   logic                  sw_rst_req;
   logic                  wdt_kick;
   logic [NUM_STAGES-1:0] stage_rst_n;
   logic                  all_released;
   logic [1:0]            rst_cause;

   modport master (
      output locked, sw_rst_req, wdt_kick,
      input  stage_rst_n, all_released, rst_cause
   );

   modport slave (
      input  locked, sw_rst_req, wdt_kick,
      output stage_rst_n, all_released, rst_cause
   );
endinterface

// File: rtl/rst_sequencer.sv
// Reset sequencer.
// Holds every reset domain for HOLD_CYCLES locked clocks. It then releases the
// domains one at a time, STAGE_DELAY clocks apart with bit 0 first, and
// re-enters reset on lock loss, a software request or a watchdog timeout.
// The last reset cause stays readable on rst_cause.
// Optional watchdog: define RST_SEQ_WDT_EN to build a RUN-state watchdog of
// WDT_CYCLES clocks that wdt_kick restarts. Without it, wdt_kick is ignored.
module rst_sequencer #(
   parameter int NUM_STAGES  = 3,
   parameter int HOLD_CYCLES = 32,
   parameter int STAGE_DELAY = 16,
   parameter int WDT_CYCLES  = 1048576
) (
   input logic              clk,
   input logic              rst_n,
   rst_sequencer_if.slave   bus_if
);

   // One counter serves both the hold interval and the inter-stage delay.
   // Only one of them is active at a time.
   localparam int CNT_MAX = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int IW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_EXT  = 2'b00,
      CAUSE_LOCK = 2'b01,
      CAUSE_SW   = 2'b10,
      CAUSE_WDT  = 2'b11
   } cause_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic                  all_rel_q, all_rel_d;
   cause_e                cause_q, cause_d;

   logic [CW-1:0]         cnt_inc;
   logic                  hold_done;
   logic                  delay_done;
   logic                  last_stage;
   logic                  wdt_timeout;
   logic                  abort;
   cause_e                abort_cause;

   assign cnt_inc    = cnt_q + 1'b1;
   assign hold_done  = (cnt_inc == CW'(HOLD_CYCLES));
   assign delay_done = (cnt_inc == CW'(STAGE_DELAY));
   assign last_stage = (idx_q == IW'(NUM_STAGES - 1));

`ifdef RST_SEQ_WDT_EN
   localparam int WW = $clog2(WDT_CYCLES + 1);

   logic [WW-1:0] wdt_q, wdt_d;

   // Watchdog count: runs only in RUN, so it is zero on entry to RUN; a kick restarts it.
   always_comb begin
      wdt_d       = '0;
      wdt_timeout = 1'b0;
      if ((state_q == ST_RUN) && !bus_if.wdt_kick) begin
         wdt_d = wdt_q + 1'b1;
         if (wdt_d == WW'(WDT_CYCLES)) begin
            wdt_timeout = 1'b1;
         end
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdt_q <= '0;
      end else begin
         wdt_q <= wdt_d;
      end
   end
`else
   logic unused_wdt;

   assign wdt_timeout = 1'b0;
   assign unused_wdt  = ^{bus_if.wdt_kick, 32'(WDT_CYCLES)};
`endif

   // Prioritised abort request: lock loss, then watchdog, then software.
   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      abort       = 1'b0;
      abort_cause = cause_q;
      if (!bus_if.locked) begin
         abort       = 1'b1;
         abort_cause = CAUSE_LOCK;
      end else if (wdt_timeout) begin
         abort       = 1'b1;
         abort_cause = CAUSE_WDT;
      end else if (bus_if.sw_rst_req) begin
         abort       = 1'b1;
         abort_cause = CAUSE_SW;
      end
   end

   // FSM state register.
   // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_HOLD;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_HOLD: begin
            if (bus_if.locked && !bus_if.sw_rst_req && hold_done) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (abort) begin
               state_d = ST_HOLD;
            end else if (delay_done && last_stage) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_HOLD;
            end
         end
         default: state_d = ST_HOLD;
      endcase
   end

   // Output and datapath next values: counters, stage mask, released flag, cause.
   always_comb begin
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      stage_d   = stage_q;
      all_rel_d = all_rel_q;
      cause_d   = cause_q;
      unique case (state_q)
         ST_HOLD: begin
            stage_d   = '0;
            all_rel_d = 1'b0;
            if (!bus_if.locked) begin
               // Lock not yet stable: restart the hold interval and leave the cause unchanged.
               cnt_d = '0;
            end else if (bus_if.sw_rst_req) begin
               cnt_d   = '0;
               cause_d = CAUSE_SW;
            end else if (hold_done) begin
               cnt_d = '0;
               idx_d = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_RELEASE, ST_RUN: begin
            if (abort) begin
               cnt_d     = '0;
               idx_d     = '0;
               stage_d   = '0;
               all_rel_d = 1'b0;
               cause_d   = abort_cause;
            end else if (state_q == ST_RELEASE) begin
               if (delay_done) begin
                  cnt_d   = '0;
                  stage_d = stage_q | (NUM_STAGES'(1) << idx_q);
                  if (last_stage) begin
                     all_rel_d = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: begin
            cnt_d     = '0;
            idx_d     = '0;
            stage_d   = '0;
            all_rel_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         stage_q   <= '0;
         all_rel_q <= 1'b0;
         cause_q   <= CAUSE_EXT;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         stage_q   <= stage_d;
         all_rel_q <= all_rel_d;
         cause_q   <= cause_d;
      end
   end

   assign bus_if.stage_rst_n  = stage_q;
   assign bus_if.all_released = all_rel_q;
   assign bus_if.rst_cause    = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: directed sequences followed by random
// lock drops, software requests and kicks, all checked against a timeline model.
// The model works in terms of "edges since the sequence (re)started".
// Build with RST_SEQ_WDT_EN defined to also exercise the 100-cycle watchdog.
module tb_rst_sequencer;

   localparam int NS    = 3;
   localparam int HOLD  = 32;
   localparam int DELAY = 16;
`ifdef RST_SEQ_WDT_EN
   localparam int WDT   = 100;
`else
   localparam int WDT   = 1048576;
`endif
   localparam int END_T = HOLD + NS * DELAY;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   rst_sequencer_if #(.NUM_STAGES(NS)) bus_if ();

   rst_sequencer #(
      .NUM_STAGES (NS),
      .HOLD_CYCLES(HOLD),
      .STAGE_DELAY(DELAY),
      .WDT_CYCLES (WDT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus_if(bus_if.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int edge_no  = 0;

   // Reference model state.
   int         m_t;      // edges counted since the current sequence started
   int         m_age;    // edges since RUN entry or last kick
   logic [1:0] m_cause;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s (edge %0d): got %0h expected %0h", tag, edge_no, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_t     = 0;
      m_age   = 0;
      m_cause = 2'b00;
   endtask

   // Advances the timeline model by one clock edge with the given inputs.
   task automatic model_step(input logic lk, input logic sw, input logic kick);
      logic       wdt_to;
      logic       ab;
      logic [1:0] c;
      wdt_to = 1'b0;
      ab     = 1'b0;
      c      = m_cause;
      if (m_t < HOLD) begin
         if (!lk) begin
            m_t = 0;
         end else if (sw) begin
            m_t     = 0;
            m_cause = 2'b10;
         end else begin
            m_t++;
         end
      end else begin
         if (m_t >= END_T) m_age = kick ? 0 : m_age + 1;
`ifdef RST_SEQ_WDT_EN
         wdt_to = (m_t >= END_T) && (m_age == WDT);
`endif
         if (!lk) begin
            ab = 1'b1; c = 2'b01;
         end else if (wdt_to) begin
            ab = 1'b1; c = 2'b11;
         end else if (sw) begin
            ab = 1'b1; c = 2'b10;
         end
         if (ab) begin
            m_t     = 0;
            m_cause = c;
         end else if (m_t < END_T) begin
            m_t++;
            if (m_t == END_T) m_age = 0;
         end
      end
   endtask

   function automatic int exp_released();
      int n;
      if (m_t < HOLD) return 0;
      n = (m_t - HOLD) / DELAY;
      return (n > NS) ? NS : n;
   endfunction

   task automatic check_model();
      int            n;
      logic [NS-1:0] mask;
      n    = exp_released();
      mask = NS'((1 << n) - 1);
      check("stage_rst_n", {29'd0, bus_if.stage_rst_n}, {29'd0, mask});
      check("all_released", {31'd0, bus_if.all_released}, {31'd0, (n == NS)});
      check("rst_cause", {30'd0, bus_if.rst_cause}, {30'd0, m_cause});
   endtask

   // Called while clk is low: drive, take the edge, update model, check, return at next negedge.
   task automatic step(input logic lk, input logic sw, input logic kick);
      bus_if.locked     = lk;
      bus_if.sw_rst_req = sw;
      bus_if.wdt_kick   = kick;
      @(posedge clk);
      edge_no++;
      model_step(lk, sw, kick);
      #1;
      check_model();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n             = 1'b0;
      bus_if.locked     = 1'b1;
      bus_if.sw_rst_req = 1'b0;
      bus_if.wdt_kick   = 1'b0;
      model_reset();
      #1;
      check("rst.stage_rst_n", {29'd0, bus_if.stage_rst_n}, 32'd0);
      check("rst.all_released", {31'd0, bus_if.all_released}, 32'd0);
      check("rst.rst_cause", {30'd0, bus_if.rst_cause}, 32'd0);
      repeat (5) @(negedge clk);
      rst_n   = 1'b1;
      edge_no = 0;
   endtask

   initial begin
      rst_n             = 1'b0;
      bus_if.locked     = 1'b0;
      bus_if.sw_rst_req = 1'b0;
      bus_if.wdt_kick   = 1'b0;
      @(negedge clk);

      // Power-up with locked steady (watchdog build: no kicks, timeout at 180).
      do_reset();
      for (int i = 0; i < 200; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (edge_no == 47) check("pwr.e47", {29'd0, bus_if.stage_rst_n}, 32'b000);
         if (edge_no == 48) check("pwr.e48", {29'd0, bus_if.stage_rst_n}, 32'b001);
         if (edge_no == 64) check("pwr.e64", {29'd0, bus_if.stage_rst_n}, 32'b011);
         if (edge_no == 79) check("pwr.e79_all", {31'd0, bus_if.all_released}, 32'd0);
         if (edge_no == 80) check("pwr.e80", {29'd0, bus_if.stage_rst_n}, 32'b111);
         if (edge_no == 80) check("pwr.e80_all", {31'd0, bus_if.all_released}, 32'd1);
`ifdef RST_SEQ_WDT_EN
         if (edge_no == 180) check("wdt.e180_cause", {30'd0, bus_if.rst_cause}, 32'b11);
         if (edge_no == 180) check("wdt.e180_stage", {29'd0, bus_if.stage_rst_n}, 32'b000);
`else
         if (edge_no == 180) check("pwr.e180_cause", {30'd0, bus_if.rst_cause}, 32'b00);
`endif
      end

      // Lock loss during HOLD (edges 20-29), then a software request in RUN at edge 121.
      do_reset();
      for (int i = 0; i < 215; i++) begin
         if (edge_no + 1 >= 20 && edge_no + 1 <= 29) step(1'b0, 1'b0, 1'b0);
         else if (edge_no + 1 == 121)                step(1'b1, 1'b1, 1'b0);
         else                                        step(1'b1, 1'b0, 1'b0);
         if (edge_no == 76)  check("lock.e76", {29'd0, bus_if.stage_rst_n}, 32'b000);
         if (edge_no == 77)  check("lock.e77", {29'd0, bus_if.stage_rst_n}, 32'b001);
         if (edge_no == 109) check("lock.e109", {29'd0, bus_if.stage_rst_n}, 32'b111);
         if (edge_no == 109) check("lock.e109_cause", {30'd0, bus_if.rst_cause}, 32'b00);
         if (edge_no == 121) check("sw.e121_stage", {29'd0, bus_if.stage_rst_n}, 32'b000);
         if (edge_no == 121) check("sw.e121_cause", {30'd0, bus_if.rst_cause}, 32'b10);
         if (edge_no == 169) check("sw.e169", {29'd0, bus_if.stage_rst_n}, 32'b001);
         if (edge_no == 201) check("sw.e201_all", {31'd0, bus_if.all_released}, 32'd1);
      end

      // Lock loss and software request together in RUN: lock loss wins.
      step(1'b0, 1'b1, 1'b0);
      check("both.cause", {30'd0, bus_if.rst_cause}, 32'b01);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);

      // Async reset between edges after stage 0 released; cause is 10 beforehand.
      do_reset();
      for (int i = 0; i < 55; i++) begin
         if (edge_no + 1 == 3) step(1'b1, 1'b1, 1'b0);
         else                  step(1'b1, 1'b0, 1'b0);
      end
      check("arst.pre_stage", {29'd0, bus_if.stage_rst_n}, 32'b001);
      check("arst.pre_cause", {30'd0, bus_if.rst_cause}, 32'b10);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst.stage", {29'd0, bus_if.stage_rst_n}, 32'b000);
      check("arst.all", {31'd0, bus_if.all_released}, 32'd0);
      check("arst.cause", {30'd0, bus_if.rst_cause}, 32'b00);
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      edge_no = 0;

      // Regular kicks every 50 edges keep the sequencer in RUN.
      for (int i = 0; i < 500; i++) begin
         step(1'b1, 1'b0, ((edge_no + 1) % 50) == 0);
      end
      check("kick.all", {31'd0, bus_if.all_released}, 32'd1);

      // Randomised lock drops, software requests and kicks.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 299) == 0),
              ($urandom_range(0, 39) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
